ram_access_ctrl: RTL

//  Initiator side of the 32-bit word RAM port. Takes 64-bit double-word or 32-bit single-word requests

---
 rtl/ram_access_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// Initiator for the 32-bit word RAM port: splits single/double-word core requests into
// one or two RAM accesses and returns data/status on a valid/ready response channel.
module ram_access_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic          req_dbl,
  input  logic [AW-1:0] req_addr_hi,
  input  logic [AW-1:0] req_addr_lo,
  input  logic [63:0]   req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [63:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic          mem_rd,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC_HI, ACC_LO, RESP} state_t;

  state_t        state;
  logic [AW-1:0] lo_addr;
  logic [31:0]   lo_wdata;
  logic          addr_ok;

  function automatic logic in_range(input logic [AW-1:0] addr);
    return addr < AW'(DEPTH);
  endfunction

  assign addr_ok   = in_range(req_addr_lo) && (!req_dbl || in_range(req_addr_hi));
  assign req_ready = (state == IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_wr     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lo_addr    <= '0;
      lo_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lo_addr    <= req_addr_lo;
            lo_wdata   <= req_wr ? req_wdata[31:0] : 32'h0;
            resp_rdata <= '0;
            resp_err   <= !addr_ok;
            if (!addr_ok) begin
              state <= RESP;
            end else begin
              mem_wr    <= req_wr;
              mem_rd    <= !req_wr;
              mem_addr  <= req_dbl ? req_addr_hi : req_addr_lo;
              mem_wdata <= !req_wr ? 32'h0 : (req_dbl ? req_wdata[63:32] : req_wdata[31:0]);
              state     <= req_dbl ? ACC_HI : ACC_LO;
            end
          end
        end
        // RAM acted on the negedge of this cycle; read data is valid at this posedge
        ACC_HI: begin
          if (mem_rd) resp_rdata[63:32] <= mem_rdata;
          mem_addr  <= lo_addr;
          mem_wdata <= lo_wdata;
          state     <= ACC_LO;
        end
        ACC_LO: begin
          if (mem_rd) resp_rdata[31:0] <= mem_rdata;
          mem_wr     <= 1'b0;
          mem_rd     <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        // A rejected request enters with resp_valid low, giving it the same 1-clock latency
        RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
